restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/divider_pkg.sv | 17 +
 rtl/divider_datapath.sv | 60 ++++++
 rtl/restoring_divider.sv | 184 ++++++++++++++++++
 tb/tb_restoring_divider.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and default width.
// Latency: none (package only).
// Backpressure: none (package only).
package divider_pkg;

  // Default divisor/quotient/remainder width; the dividend is twice this.
  localparam int DIV_N_DEFAULT = 4;

  // Controller states: accept, shift/subtract iterations, sign fix-up, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/divider_datapath.sv
// Shift/trial-subtract engine: holds {partial remainder, dividend} and the divisor.
// Latency: one quotient bit per step cycle; load takes effect on the next edge.
// Backpressure: none; the controller owns sequencing through load/step.
module divider_datapath #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic [2*N-1:0] dvd_in,
  input  logic [N-1:0]   div_in,
  output logic [N-1:0]   quo,
  output logic [N-1:0]   rem
);

  // Upper half of acc is the partial remainder, lower half fills with quotient bits.
  logic [2*N-1:0] acc_q, acc_d;
  logic [N-1:0]   dvs_q, dvs_d;
  logic [2*N:0]   shifted;
  logic [N:0]     upper;
  logic [N:0]     trial;
  logic           borrow;
  logic           nonneg;
  // The top trial bit is always zero when the subtraction is kept, so it is never stored.
  logic           unused_trial_msb;

  // One restoring iteration: shift left, subtract on N+1 bits, keep or restore.
  always_comb begin
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    shifted = {acc_q, 1'b0};
    upper   = shifted[2*N:N];
    {borrow, trial} = {1'b0, upper} - {2'b00, dvs_q};
    nonneg  = ~borrow;
    if (load) begin
      acc_d = dvd_in;
      dvs_d = div_in;
    end else if (step) begin
      acc_d = {(nonneg ? trial[N-1:0] : upper[N-1:0]), shifted[N-1:1], nonneg};
    end
  end

  assign unused_trial_msb = trial[N];

  // Operand/accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      dvs_q <= '0;
    end else begin
      acc_q <= acc_d;
      dvs_q <= dvs_d;
    end
  end

  assign quo = acc_q[N-1:0];
  assign rem = acc_q[2*N-1:N];

endmodule

// File: rtl/restoring_divider.sv
// 2N/N restoring divider with zero-divisor and overflow short-cuts; DIVIDER_SIGNED_EN enables two's complement.
// Latency: done in the (N+2)th cycle after acceptance, or the first cycle for zero divisor / overflow.
// Backpressure: start is only sampled in IDLE; requests while busy or in DONE are dropped.
module restoring_divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = $clog2(N + 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [N-1:0]    rem_q, rem_d;
  logic            dz_q, dz_d;
  logic            ov_q, ov_d;
  logic            dp_load, dp_step;
  logic [2*N-1:0]  dvd_mag;
  logic [N-1:0]    div_mag;
  logic [N-1:0]    dp_quo, dp_rem;
  logic [N-1:0]    fix_quo, fix_rem;
  logic            fix_ov;
  logic            div_zero, hi_ovf;

`ifdef DIVIDER_SIGNED_EN
  // Most negative quotient magnitude; reachable only when the signs differ.
  localparam logic [N-1:0] Q_LIM = {1'b1, {(N-1){1'b0}}};

  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;

  // Operand magnitudes and result sign capture at acceptance.
  always_comb begin
    dvd_mag = dividend[2*N-1] ? -dividend : dividend;
    div_mag = divisor[N-1] ? -divisor : divisor;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    if (state_q == IDLE && start) begin
      qneg_d = dividend[2*N-1] ^ divisor[N-1];
      rneg_d = dividend[2*N-1];
    end
  end

  // Sign correction applied in FIX, plus the signed range check on the quotient.
  always_comb begin
    fix_ov  = qneg_q ? (dp_quo > Q_LIM) : (dp_quo >= Q_LIM);
    fix_quo = qneg_q ? -dp_quo : dp_quo;
    fix_rem = rneg_q ? -dp_rem : dp_rem;
  end

  // Result sign registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
    end
  end
`else
  assign dvd_mag = dividend;
  assign div_mag = divisor;
  assign fix_ov  = 1'b0;
  assign fix_quo = dp_quo;
  assign fix_rem = dp_rem;
`endif

  // A high half not below the divisor means the quotient cannot fit in N bits.
  assign div_zero = (divisor == '0);
  assign hi_ovf   = !div_zero && (dvd_mag[2*N-1:N] >= div_mag);

  // Next-state and result-register logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    ov_d    = ov_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dp_load = 1'b1;
          cnt_d   = '0;
          dz_d    = 1'b0;
          ov_d    = 1'b0;
          if (div_zero) begin
            quo_d   = '1;
            rem_d   = dividend[N-1:0];
            dz_d    = 1'b1;
            state_d = DONE;
          end else if (hi_ovf) begin
            quo_d   = '1;
            rem_d   = '0;
            ov_d    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        dp_step = 1'b1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        if (fix_ov) begin
          quo_d = '1;
          rem_d = '0;
          ov_d  = 1'b1;
        end else begin
          quo_d = fix_quo;
          rem_d = fix_rem;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Controller and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      ov_q    <= ov_d;
    end
  end

  divider_datapath #(
    .N(N)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst),
    .load   (dp_load),
    .step   (dp_step),
    .dvd_in (dvd_mag),
    .div_in (div_mag),
    .quo    (dp_quo),
    .rem    (dp_rem)
  );

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == ITER) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign div_by_zero = dz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (N=4): vector table, random ops and corner sequences.
// Latency: expected results are queued at acceptance and compared when done pulses.
// Backpressure: operations are issued only when the divider is idle, except in the drop tests.
module tb_restoring_divider;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [7:0]   dividend;
  logic [3:0]   divisor;
  logic [3:0]   quotient;
  logic [3:0]   remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic         overflow;

  restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    bit         fast;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       ov;
    bit         fast;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference of the divider's results.
  function automatic exp_t model(input logic [7:0] dvd, input logic [3:0] dvs);
    exp_t e;
    e.q = 4'h0; e.r = 4'h0; e.dz = 1'b0; e.ov = 1'b0; e.fast = 1'b0; e.acc = 0;
    if (dvs == 4'h0) begin
      e.q = 4'hF; e.r = dvd[3:0]; e.dz = 1'b1; e.fast = 1'b1;
      return e;
    end
`ifdef DIVIDER_SIGNED_EN
    begin
      int sd, sv, ad, av, qi, ri, qs;
      sd = $signed(dvd);
      sv = $signed(dvs);
      ad = (sd < 0) ? -sd : sd;
      av = (sv < 0) ? -sv : sv;
      if ((ad / 16) >= av) begin
        e.q = 4'hF; e.ov = 1'b1; e.fast = 1'b1;
      end else begin
        qi = ad / av;
        ri = ad % av;
        qs = ((sd < 0) != (sv < 0)) ? -qi : qi;
        if (qs < -8 || qs > 7) begin
          e.q = 4'hF; e.ov = 1'b1;
        end else begin
          e.q = 4'(qs);
          e.r = 4'((sd < 0) ? -ri : ri);
        end
      end
    end
`else
    if (dvd[7:4] >= dvs) begin
      e.q = 4'hF; e.ov = 1'b1; e.fast = 1'b1;
    end else begin
      e.q = 4'(int'(dvd) / int'(dvs));
      e.r = 4'(int'(dvd) % int'(dvs));
    end
`endif
    return e;
  endfunction

  // Scoreboard side: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 want no pending operation (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
        check("overflow", 32'(overflow), 32'(e.ov));
        check("busy_at_done", 32'(busy), 32'd0);
        check("latency", 32'(cyc - e.acc + 1), e.fast ? 32'd1 : 32'(N + 2));
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((busy || done) && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation, scramble the operands after acceptance, wait for done and check hold.
  task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs, input exp_t e);
    int d0;
    int t;
    wait_idle();
    d0 = done_cnt;
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    e.acc    = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("busy_after_accept", 32'(busy), e.fast ? 32'd0 : 32'd1);
    if (!e.fast) begin
      check("flags_cleared", 32'({div_by_zero, overflow}), 32'd0);
    end
    t = 0;
    while (done_cnt == d0 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check("done_timeout", 32'(done_cnt - d0), 32'd1);
    repeat (2) @(negedge clk);
    check("hold_result", 32'({quotient, remainder, div_by_zero, overflow}),
          32'({e.q, e.r, e.dz, e.ov}));
  endtask

  vec_t tbl[12];

  initial begin
    exp_t e;
    int   d0;

`ifdef DIVIDER_SIGNED_EN
    tbl[0]  = '{8'hCE, 4'd7, 4'h9, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'd50, 4'd0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{8'd100, 4'd7, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{8'hCE, 4'hF9, 4'h7, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'h32, 4'hF9, 4'h9, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hC8, 4'd7, 4'h8, 4'h0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{8'h38, 4'd7, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{8'd9, 4'd2, 4'h4, 4'h1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'h80, 4'h8, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{8'hF9, 4'd2, 4'hD, 4'hF, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{8'hFF, 4'd0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{8'd0, 4'd5, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
`else
    tbl[0]  = '{8'd100, 4'd7, 4'd14, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{8'd50, 4'd0, 4'hF, 4'h2, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{8'd200, 4'd3, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[3]  = '{8'd9, 4'd2, 4'd4, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{8'd0, 4'd5, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{8'hFF, 4'd0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{8'h0F, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{8'h7F, 4'd8, 4'd15, 4'd7, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{8'hEF, 4'd15, 4'd15, 4'd14, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{8'h10, 4'd1, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[10] = '{8'h50, 4'd5, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{8'h4F, 4'd5, 4'd15, 4'd4, 1'b0, 1'b0, 1'b0};
`endif

    rst = 1'b0;
    start = 1'b0;
    dividend = 8'h0;
    divisor = 4'h0;
    #1;
    check("reset_outputs", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Vector table.
    for (int i = 0; i < 12; i++) begin
      e.q = tbl[i].q; e.r = tbl[i].r; e.dz = tbl[i].dz; e.ov = tbl[i].ov;
      e.fast = tbl[i].fast; e.acc = 0;
      do_op(tbl[i].dvd, tbl[i].dvs, e);
    end

    // Random operations, biased toward representable quotients.
    for (int i = 0; i < 24; i++) begin
      logic [7:0] dvd;
      logic [3:0] dvs;
      dvs = 4'($urandom_range(0, 15));
      dvd = 8'($urandom);
      if (i % 2 == 0 && dvs != 4'h0) dvd[7:4] = 4'($urandom_range(0, int'(dvs) - 1));
      do_op(dvd, dvs, model(dvd, dvs));
    end

    // Reset in the middle of an operation aborts it with no done pulse.
    wait_idle();
    d0 = done_cnt;
    dividend = 8'd100;
    divisor = 4'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
    @(negedge clk);
    check("rst_held_outputs", 32'({quotient, remainder, busy, done, div_by_zero, overflow}), 32'd0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("no_done_after_abort", 32'(done_cnt - d0), 32'd0);
    do_op(8'd9, 4'd2, model(8'd9, 4'd2));

    // Start while busy is dropped: one done, first operation's result.
    wait_idle();
    d0 = done_cnt;
    dividend = 8'd100;
    divisor = 4'd7;
    start = 1'b1;
    e = model(8'd100, 4'd7);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 8'd30;
    divisor = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("single_done_busy", 32'(done_cnt - d0), 32'd1);
    check("busy_drop_result", 32'({quotient, remainder}), 32'({e.q, e.r}));

    // Start during the DONE cycle is dropped too.
    wait_idle();
    d0 = done_cnt;
    dividend = 8'd50;
    divisor = 4'd0;
    start = 1'b1;
    e = model(8'd50, 4'd0);
    e.acc = cyc + 1;
    sbq.push_back(e);
    @(negedge clk);
    dividend = 8'd30;
    divisor = 4'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("single_done_in_done", 32'(done_cnt - d0), 32'd1);
    check("done_drop_busy", 32'(busy), 32'd0);
    check("done_drop_result", 32'({quotient, remainder, div_by_zero}), 32'({e.q, e.r, e.dz}));

    check("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
